// File: rtl/operand_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : operand_serializer
//  Description : Accepts an operand pair through a valid/ready load port and
//                presents both operands LSB-first, one bit pair per clock,
//                with sof/eof framing and a carry seed for a serial adder.
//                Back-to-back frames run without an idle gap: a new pair is
//                accepted on the edge that retires the last bit of a frame.
//                Optional feature macro: SERIALIZER_SUB_EN adds the `sub`
//                port (operand B inverted, carry seeded with 1 => A-B).
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef SERIALIZER_SUB_EN
  input  logic             sub,
`endif
  output logic             bit_a,
  output logic             bit_b,
  output logic             bit_valid,
  output logic             sof,
  output logic             eof,
  output logic             cin_init,
  output logic             busy
);

  // Bit counter wide enough to index every bit of a frame.
  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Frame state encoding.
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic w_in_shift;
  logic w_last;
  logic w_accept;
  logic w_sub_req;
  logic w_sub_cur;

`ifdef SERIALIZER_SUB_EN
  logic sub_q, sub_d;

  assign w_sub_req = sub;
  assign w_sub_cur = sub_q;
`else
  // Without the subtract feature the B path is always a straight add.
  assign w_sub_req = 1'b0;
  assign w_sub_cur = 1'b0;
`endif

  // Frame status decoded purely from registers; load_ready never looks at
  // load_valid, so the handshake cannot form a combinational loop upstream.
  assign w_in_shift = (state_q == S_SHIFT);
  assign w_last     = w_in_shift && (cnt_q == CNT_LAST);
  assign w_accept   = load_valid && load_ready;

  // State register: reset aborts any frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a load on the final bit keeps us in SHIFT for a gapless frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_last && !w_accept) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs: every flag is gated by SHIFT so IDLE and reset read all-zero.
  always_comb begin
    bit_valid  = w_in_shift;
    busy       = w_in_shift;
    bit_a      = w_in_shift && sh_a_q[0];
    bit_b      = w_in_shift && sh_b_q[0];
    sof        = w_in_shift && (cnt_q == CNT_ZERO);
    eof        = w_last;
    cin_init   = w_in_shift && (cnt_q == CNT_ZERO) && w_sub_cur;
    load_ready = !w_in_shift || w_last;
  end

  // Datapath next state: capture on accept, otherwise shift while framing.
  always_comb begin
    sh_a_d = sh_a_q;
    sh_b_d = sh_b_q;
    cnt_d  = cnt_q;
    if (w_accept) begin
      sh_a_d = op_a;
      sh_b_d = w_sub_req ? ~op_b : op_b;
      cnt_d  = CNT_ZERO;
    end else if (w_in_shift) begin
      sh_a_d = {1'b0, sh_a_q[WIDTH-1:1]};
      sh_b_d = {1'b0, sh_b_q[WIDTH-1:1]};
      // Park the counter at zero when the frame ends so IDLE is clean even
      // when WIDTH is not a power of two.
      cnt_d  = w_last ? CNT_ZERO : (cnt_q + CNT_ONE);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_a_q <= '0;
      sh_b_q <= '0;
      cnt_q  <= CNT_ZERO;
    end else begin
      sh_a_q <= sh_a_d;
      sh_b_q <= sh_b_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef SERIALIZER_SUB_EN
  // Subtract flag is held for the whole frame; only its sof cycle matters.
  always_comb begin
    sub_d = sub_q;
    if (w_accept) begin
      sub_d = sub;
    end
  end

  // Subtract flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_q <= 1'b0;
    end else begin
      sub_q <= sub_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_operand_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand_serializer
//  Description : Self-checking bench for operand_serializer (WIDTH=8) with a
//                frame-level reference model (queue of expected bit slots).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_serializer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         load_ready, bit_a, bit_b, bit_valid, sof, eof, cin_init, busy;

  always #5 clk = ~clk;

  operand_serializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .op_a       (op_a),
    .op_b       (op_b),
`ifdef SERIALIZER_SUB_EN
    .sub        (sub),
`endif
    .bit_a      (bit_a),
    .bit_b      (bit_b),
    .bit_valid  (bit_valid),
    .sof        (sof),
    .eof        (eof),
    .cin_init   (cin_init),
    .busy       (busy)
  );

  // One expected slot per presented frame bit.
  typedef struct {
    logic a;
    logic b;
    logic sf;
    logic ef;
    logic cin;
  } slot_t;

  slot_t q[$];
  int    checks   = 0;
  int    failures = 0;

  // Per-cycle log of DUT outputs for directed literal checks.
  logic [63:0] log_a, log_b, log_sof, log_eof, log_cin, log_v, log_r;
  int          log_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_log();
    log_a = '0; log_b = '0; log_sof = '0; log_eof = '0;
    log_cin = '0; log_v = '0; log_r = '0; log_n = 0;
  endtask

  // Expand one accepted operand pair into its WIDTH expected bit slots.
  task automatic push_frame(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    slot_t e;
    logic  s_eff;
`ifdef SERIALIZER_SUB_EN
    s_eff = s;
`else
    s_eff = 1'b0;
`endif
    for (int i = 0; i < W; i++) begin
      e.a   = a[i];
      e.b   = s_eff ? ~b[i] : b[i];
      e.sf  = (i == 0);
      e.ef  = (i == W - 1);
      e.cin = s_eff && (i == 0);
      q.push_back(e);
    end
  endtask

  // Compare current DUT outputs against the model's view of this cycle.
  task automatic check_outputs();
    chk("load_ready", {31'd0, load_ready}, {31'd0, (q.size() <= 1)});
    if (q.size() == 0) begin
      chk("idle_bit_valid", {31'd0, bit_valid}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_sof", {31'd0, sof}, 32'd0);
      chk("idle_eof", {31'd0, eof}, 32'd0);
      chk("idle_cin_init", {31'd0, cin_init}, 32'd0);
    end else begin
      chk("bit_valid", {31'd0, bit_valid}, 32'd1);
      chk("busy", {31'd0, busy}, 32'd1);
      chk("bit_a", {31'd0, bit_a}, {31'd0, q[0].a});
      chk("bit_b", {31'd0, bit_b}, {31'd0, q[0].b});
      chk("sof", {31'd0, sof}, {31'd0, q[0].sf});
      chk("eof", {31'd0, eof}, {31'd0, q[0].ef});
      chk("cin_init", {31'd0, cin_init}, {31'd0, q[0].cin});
    end
    if (log_n < 64) begin
      log_a[log_n]   = bit_a;
      log_b[log_n]   = bit_b;
      log_sof[log_n] = sof;
      log_eof[log_n] = eof;
      log_cin[log_n] = cin_init;
      log_v[log_n]   = bit_valid;
      log_r[log_n]   = load_ready;
    end
    log_n++;
  endtask

  // One clock cycle: check, drive, advance the model at the rising edge.
  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic acc;
    check_outputs();
    load_valid = v;
    op_a       = a;
    op_b       = b;
    sub        = s;
    acc        = v && (q.size() <= 1);
    @(posedge clk);
    if (q.size() > 0) q.delete(0);
    if (acc) push_frame(a, b, s);
    @(negedge clk);
  endtask

  // Asynchronous reset pulse mid-cycle, with a load offered during reset.
  task automatic do_reset();
    #2;
    rst        = 1'b1;
    load_valid = 1'b1;
    op_a       = 8'hC3;
    op_b       = 8'h3C;
    #1;
    chk("rst_bit_valid", {31'd0, bit_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sof", {31'd0, sof}, 32'd0);
    chk("rst_eof", {31'd0, eof}, 32'd0);
    chk("rst_cin_init", {31'd0, cin_init}, 32'd0);
    chk("rst_load_ready", {31'd0, load_ready}, 32'd1);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("rst_no_capture", {31'd0, bit_valid}, 32'd0);
    rst        = 1'b0;
    load_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    op_a       = '0;
    op_b       = '0;
    sub        = 1'b0;
    clear_log();
    #1;
    chk("por_bit_valid", {31'd0, bit_valid}, 32'd0);
    chk("por_load_ready", {31'd0, load_ready}, 32'd1);
    chk("por_bits", {30'd0, bit_a, bit_b}, 32'd0);
    chk("por_flags", {28'd0, sof, eof, cin_init, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0);

    // Single frame a=5A b=0F.
    clear_log();
    step(1'b1, 8'h5A, 8'h0F, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, '0, '0, 1'b0);
    chk("single_a", {24'd0, log_a[8:1]}, 32'h5A);
    chk("single_b", {24'd0, log_b[8:1]}, 32'h0F);
    chk("single_sof", {22'd0, log_sof[9:0]}, 32'h002);
    chk("single_eof", {22'd0, log_eof[9:0]}, 32'h100);
    chk("single_valid", {22'd0, log_v[9:0]}, 32'h1FE);

    // Back-to-back frames with load_valid held.
    clear_log();
    step(1'b1, 8'hFF, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 8'h01, 8'h80, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, '0, '0, 1'b0);
    chk("b2b_valid", {14'd0, log_v[17:0]}, 32'h1FFFE);
    chk("b2b_sof", {14'd0, log_sof[17:0]}, 32'h00202);
    chk("b2b_eof", {14'd0, log_eof[17:0]}, 32'h10100);
    chk("b2b_a", {16'd0, log_a[16:1]}, 32'h01FF);
    chk("b2b_b", {16'd0, log_b[16:1]}, 32'h8000);

    // Loads offered during frame bits are ignored.
    clear_log();
    step(1'b1, 8'h3C, 8'h55, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 8'hAA, 8'hAA, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0);
    chk("blocked_ready", {26'd0, log_r[7:2]}, 32'd0);
    chk("blocked_a", {24'd0, log_a[8:1]}, 32'h3C);
    chk("blocked_b", {24'd0, log_b[8:1]}, 32'h55);
    chk("blocked_end", {31'd0, log_v[9]}, 32'd0);

    // Reset mid-frame, then a clean frame a=03.
    step(1'b1, 8'h5A, 8'h0F, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0);
    do_reset();
    clear_log();
    step(1'b0, '0, '0, 1'b0);
    step(1'b1, 8'h03, 8'h00, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, '0, '0, 1'b0);
    chk("post_rst_valid_idle", {31'd0, log_v[0]}, 32'd0);
    chk("post_rst_a", {24'd0, log_a[9:2]}, 32'h03);
    chk("post_rst_sof", {22'd0, log_sof[9:0]}, 32'h004);
    chk("post_rst_eof", {22'd0, log_eof[9:0]}, 32'h200);

    // Subtract request a=10 b=01.
    clear_log();
    step(1'b1, 8'h10, 8'h01, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b0, '0, '0, 1'b0);
    chk("sub_a", {24'd0, log_a[8:1]}, 32'h10);
`ifdef SERIALIZER_SUB_EN
    chk("sub_b", {24'd0, log_b[8:1]}, 32'hFE);
    chk("sub_cin", {22'd0, log_cin[9:0]}, 32'h002);
`else
    chk("sub_b", {24'd0, log_b[8:1]}, 32'h01);
    chk("sub_cin", {22'd0, log_cin[9:0]}, 32'h000);
`endif

    // Randomized traffic with occasional asynchronous resets.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), 1'($urandom));
      end
    end
    for (int i = 0; i < W + 2; i++) step(1'b0, '0, '0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
